// File: rtl/wembley_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : wembley_pipe                                             |
// | Description : Valid/ready pipeline computing MIN3 / MAX3 / MED3 / CMP  |
// |               on three unsigned operands, with a saturating counter of |
// |               CMP results equal to 1 that leave the block.             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module wembley_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [WIDTH-1:0] Cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Yout,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [1:0]       c_MODE_MIN3 = 2'b00;
  localparam logic [1:0]       c_MODE_MAX3 = 2'b01;
  localparam logic [1:0]       c_MODE_MED3 = 2'b10;
  localparam logic [1:0]       c_MODE_CMP  = 2'b11;
  localparam logic [WIDTH-1:0] c_Y_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

  // Operation datapath (only feeds stage 1)
  logic [WIDTH-1:0] w_lo_ab;
  logic [WIDTH-1:0] w_hi_ab;
  logic [WIDTH-1:0] w_min3;
  logic [WIDTH-1:0] w_max3;
  logic [WIDTH-1:0] w_hi_ab_min_c;
  logic [WIDTH-1:0] w_med3;
  logic [WIDTH:0]   w_sum;
  logic             w_cmp;
  logic [WIDTH-1:0] w_result;

  // Pipeline stage state
  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];
  logic [1:0]       r_mode  [DEPTH];
  logic [DEPTH-1:0] w_ready;
  logic [CNT_W-1:0] r_hit_cnt;
  logic             w_out_fire;
  logic             w_hit;

  assign w_lo_ab       = (Ain < Bin) ? Ain : Bin;
  assign w_hi_ab       = (Ain < Bin) ? Bin : Ain;
  assign w_min3        = (w_lo_ab < Cin) ? w_lo_ab : Cin;
  assign w_max3        = (w_hi_ab > Cin) ? w_hi_ab : Cin;
  // median = max(min(a,b), min(max(a,b), c)); ties fall out naturally
  assign w_hi_ab_min_c = (w_hi_ab < Cin) ? w_hi_ab : Cin;
  assign w_med3        = (w_lo_ab > w_hi_ab_min_c) ? w_lo_ab : w_hi_ab_min_c;
  // one extra bit so A+B never wraps before comparing with C
  assign w_sum         = {1'b0, Ain} + {1'b0, Bin};
  assign w_cmp         = (w_sum > {1'b0, Cin});

  // Select the operation result for the captured mode
  always_comb begin
    w_result = w_min3;
    case (mode)
      c_MODE_MIN3: w_result = w_min3;
      c_MODE_MAX3: w_result = w_max3;
      c_MODE_MED3: w_result = w_med3;
      c_MODE_CMP:  w_result = w_cmp ? c_Y_ONE : '0;
      default:     w_result = w_min3;
    endcase
  end

  // Ready chain from the output back to stage 1: a stage can load when it is
  // empty or when the stage after it can take its contents this cycle
  always_comb begin
    w_ready            = '0;
    w_ready[DEPTH-1]   = !r_valid[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_ready[i] = !r_valid[i] || w_ready[i+1];
    end
  end

  assign in_ready   = w_ready[0] && !reset;
  assign out_valid  = r_valid[DEPTH-1];
  assign Yout       = r_data[DEPTH-1];
  assign hit_cnt    = r_hit_cnt;
  assign w_out_fire = r_valid[DEPTH-1] && out_ready;
  assign w_hit      = w_out_fire && (r_mode[DEPTH-1] == c_MODE_CMP) &&
                      (r_data[DEPTH-1] == c_Y_ONE);

  // Stage registers: stage 1 captures the computed result, later stages
  // only shift data and mode forward when their ready allows
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
        r_mode[i]  <= '0;
      end
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_result;
          r_mode[0] <= mode;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_ready[i]) begin
          r_valid[i] <= r_valid[i-1];
          r_data[i]  <= r_data[i-1];
          r_mode[i]  <= r_mode[i-1];
        end
      end
    end
  end

  // Saturating count of CMP results equal to 1 handed downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt <= '0;
    end else if (w_hit && (r_hit_cnt != c_CNT_MAX)) begin
      r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wembley_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_wembley_pipe                                          |
// | Description : Self-checking bench for wembley_pipe: directed cases     |
// |               plus randomized traffic against a queue-based model.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_wembley_pipe;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] Ain, Bin, Cin;
  logic [1:0] mode;
  logic       out_ready;
  logic       in_ready, out_valid;
  logic [3:0] Yout;
  logic [7:0] hit_cnt;
  logic       in_ready2, out_valid2;
  logic [3:0] Yout2;
  logic [1:0] hit_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wembley_pipe #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .Cin(Cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .Yout(Yout), .hit_cnt(hit_cnt)
  );

  wembley_pipe #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .Ain(Ain), .Bin(Bin), .Cin(Cin), .mode(mode), .out_valid(out_valid2),
    .out_ready(out_ready), .Yout(Yout2), .hit_cnt(hit_cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference operation straight from the mode definitions
  function automatic logic [3:0] ref_op(input int a, input int b, input int c, input logic [1:0] m);
    int lo, hi;
    lo = (a < b) ? a : b;
    lo = (lo < c) ? lo : c;
    hi = (a > b) ? a : b;
    hi = (hi > c) ? hi : c;
    case (m)
      2'b00:   return 4'(lo);
      2'b01:   return 4'(hi);
      2'b10:   return 4'(a + b + c - lo - hi);
      default: return (a + b > c) ? 4'd1 : 4'd0;
    endcase
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Model: results in acceptance order, each tagged with its accept edge;
  // the oldest result is visible DEPTH-1 edges after it was accepted.
  typedef struct packed {
    logic [3:0] y;
    logic       hit;
    int         acc;
  } item_t;

  item_t q[$];
  int    now     = 0;
  int    hits    = 0;
  bit    started = 0;

  always @(negedge clk) begin
    logic  exp_ir, exp_ov;
    item_t it;
    exp_ir = !reset && ((q.size() < DEPTH) || out_ready);
    exp_ov = (q.size() > 0) && (now >= q[0].acc + DEPTH - 1);
    if (started) begin
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) chk("Yout", Yout, q[0].y);
      chk("hit_cnt", hit_cnt, sat(hits, 255));
      chk("sat_in_ready", in_ready2, exp_ir);
      chk("sat_out_valid", out_valid2, exp_ov);
      if (exp_ov) chk("sat_Yout", Yout2, q[0].y);
      chk("sat_hit_cnt", hit_cnt2, sat(hits, 3));
    end
    if (reset) begin
      q.delete();
      hits    = 0;
      started = 1;
    end else if (started) begin
      if (exp_ov && out_ready) begin
        if (q[0].hit) hits++;
        void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        it.y   = ref_op(int'(Ain), int'(Bin), int'(Cin), mode);
        it.hit = (mode == 2'b11) && (it.y == 4'd1);
        it.acc = now + 1;
        q.push_back(it);
      end
    end
    now++;
  end

  // One operation on an empty pipeline with out_ready=1; pins the latency
  task automatic single(input logic [3:0] a, b, c, input logic [1:0] m,
                        input logic [3:0] exp, input string nm);
    in_valid = 1'b1; Ain = a; Bin = b; Cin = c; mode = m;
    @(negedge clk); chk({nm, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; Ain = 4'($urandom); Bin = 4'($urandom); Cin = 4'($urandom);
    mode = 2'($urandom);
    @(negedge clk); chk({nm, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk({nm, "_valid"}, out_valid, 1); chk({nm, "_y"}, Yout, exp);
    @(posedge clk); #1;
  endtask

  logic [3:0] sa[4], sb[4], sc[4];
  logic [1:0] sm[4];

  initial begin
    int idx, nout;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Ain = '0; Bin = '0; Cin = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // CMP cases, including the carry case
    single(4'd1, 4'd3, 4'd15, 2'b11, 4'd0, "cmp_1_3_15");
    single(4'd15, 4'd15, 4'd15, 2'b11, 4'd1, "cmp_carry");
    single(4'd6, 4'd11, 4'd1, 2'b11, 4'd1, "cmp_6_11_1");
    @(negedge clk); chk("hit_cnt_after_cmp", hit_cnt, 2);
    @(posedge clk); #1;

    single(4'd0, 4'd15, 4'd10, 2'b00, 4'd0, "min3");
    single(4'd0, 4'd15, 4'd10, 2'b01, 4'd15, "max3");

    // Back-to-back MED3
    in_valid = 1'b1; Ain = 4'd9; Bin = 4'd8; Cin = 4'd10; mode = 2'b10;
    @(posedge clk); #1;
    Ain = 4'd2; Bin = 4'd11; Cin = 4'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("med_a_valid", out_valid, 1); chk("med_a_y", Yout, 9);
    @(posedge clk); #1;
    @(negedge clk); chk("med_b_valid", out_valid, 1); chk("med_b_y", Yout, 11);
    @(posedge clk); #1;

    // Back-pressure: 4 sets offered while out_ready=0 for 6 cycles
    sa = '{4'd1, 4'd1, 4'd7, 4'd9}; sb = '{4'd2, 4'd2, 4'd7, 4'd9};
    sc = '{4'd3, 4'd3, 4'd1, 4'd2}; sm = '{2'b00, 2'b01, 2'b10, 2'b11};
    idx = 0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; Ain = sa[idx]; Bin = sb[idx]; Cin = sc[idx]; mode = sm[idx];
      @(negedge clk); if (in_ready) idx++;
      @(posedge clk); #1;
    end
    Ain = sa[idx]; Bin = sb[idx]; Cin = sc[idx]; mode = sm[idx];
    @(negedge clk);
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_hold_y", Yout, 1);
    @(posedge clk); #1;
    out_ready = 1'b1; nout = 0;
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin Ain = sa[idx]; Bin = sb[idx]; Cin = sc[idx]; mode = sm[idx]; end
      @(negedge clk);
      if (out_valid) nout++;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("release_count", nout, 4);
    chk("release_accepted", idx, 4);

    // Counter saturation on the CNT_W=2 instance (5 hits in total)
    single(4'd8, 4'd8, 4'd15, 2'b11, 4'd1, "cmp_8_8_15");
    single(4'd15, 4'd1, 4'd0, 2'b11, 4'd1, "cmp_15_1_0");
    @(negedge clk);
    chk("hit_cnt_5", hit_cnt, 5);
    chk("hit_cnt_sat3", hit_cnt2, 3);
    @(posedge clk); #1;

    // Reset with two results in flight
    out_ready = 1'b0; in_valid = 1'b1;
    Ain = 4'd4; Bin = 4'd5; Cin = 4'd6; mode = 2'b01;
    @(posedge clk); #1;
    Ain = 4'd9; Bin = 4'd9; Cin = 4'd9; mode = 2'b11;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); chk("reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_hit_cnt", hit_cnt, 0);
    chk("post_reset_Yout", Yout, 0);
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk); chk("no_stale", out_valid, 0);
      @(posedge clk); #1;
    end
    single(4'd3, 4'd5, 4'd4, 2'b00, 4'd3, "min3_after_reset");

    // Randomized traffic with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset     = ($urandom_range(199) == 0);
      in_valid  = $urandom_range(1) == 1;
      Ain       = 4'($urandom);
      Bin       = 4'($urandom);
      Cin       = 4'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(9) < 7);
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
